// File: rtl/mem_responder.sv
// mem_responder: unified word memory slave with a request/response handshake and WAIT_CYCLES wait states.
// Define MEM_BYTE_LANE_EN to add the req_byte input for LDRB/STRB byte-lane accesses.
module mem_responder #(
   parameter int ADDR_W      = 6,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
`ifdef MEM_BYTE_LANE_EN
   input  logic        req_byte,
`endif
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int         DEPTH     = 2**ADDR_W;
   localparam logic [7:0] WAIT_INIT = 8'(WAIT_CYCLES);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t            state, state_nxt;
   logic [7:0]        cnt, cnt_nxt;
   logic              enter_resp;
   logic [31:0]       addr_q, wdata_q;
   logic              we_q;
   logic [31:0]       acc_addr, acc_wdata;
   logic              acc_we, acc_byte, acc_err;
   logic [ADDR_W-1:0] acc_idx;
   logic [1:0]        acc_lane;
   logic [31:0]       rd_word, rd_data, wr_word;
   logic [7:0]        rd_byte;
   logic [31:0]       mem [DEPTH];

   assign req_ready = (state == S_IDLE);
   assign rsp_valid = (state == S_RESP);

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      enter_resp = 1'b0;
      case (state)
         S_IDLE: if (req_valid) begin
            cnt_nxt = WAIT_INIT;
            if (WAIT_CYCLES == 0) begin
               state_nxt  = S_RESP;
               enter_resp = 1'b1;
            end else begin
               state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_nxt = cnt - 8'd1;
            if (cnt == 8'd1) begin
               state_nxt  = S_RESP;
               enter_resp = 1'b1;
            end
         end
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // With zero wait states the access happens on the acceptance edge, before the holding registers load.
   assign acc_addr  = (state == S_IDLE) ? req_addr  : addr_q;
   assign acc_wdata = (state == S_IDLE) ? req_wdata : wdata_q;
   assign acc_we    = (state == S_IDLE) ? req_we    : we_q;
`ifdef MEM_BYTE_LANE_EN
   logic byte_q;
   assign acc_byte  = (state == S_IDLE) ? req_byte  : byte_q;
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                              byte_q <= 1'b0;
      else if (state == S_IDLE && req_valid) byte_q <= req_byte;
   end
`else
   assign acc_byte  = 1'b0;
`endif

   assign acc_idx  = acc_addr[ADDR_W+1:2];
   assign acc_lane = acc_addr[1:0];
   assign acc_err  = ((acc_lane != 2'd0) && !acc_byte) || (acc_addr[31:ADDR_W+2] != '0);

   assign rd_word = mem[acc_idx];
   assign rd_byte = rd_word[{acc_lane, 3'b000} +: 8];
   assign rd_data = acc_byte ? {24'h0, rd_byte} : rd_word;

   always_comb begin
      wr_word = acc_wdata;
      if (acc_byte) begin
         wr_word = rd_word;
         wr_word[{acc_lane, 3'b000} +: 8] = acc_wdata[7:0];
      end
   end

   // NOTE: the array has no reset; reset only returns control to IDLE and leaves contents intact.
   always_ff @(posedge clk) begin
      if (enter_resp && acc_we && !acc_err && !reset)
         mem[acc_idx] <= wr_word;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         cnt       <= 8'd0;
         addr_q    <= 32'd0;
         wdata_q   <= 32'd0;
         we_q      <= 1'b0;
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (state == S_IDLE && req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            we_q    <= req_we;
         end
         if (enter_resp) begin
            rsp_err   <= acc_err;
            rsp_rdata <= acc_err ? 32'd0 : (acc_we ? acc_wdata : rd_data);
         end
      end
   end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle ARM core: the slave end of the core's memory request interface (address select, MemW, read data into the instruction/data registers).
- Unified instruction/data word memory with a request/response handshake and a programmable number of wait states, so the core's control FSM can be exercised against non-single-cycle memory.
- Sits between the core datapath's Adr/WriteData/ReadData nets and a synchronous word array held inside this block.

Parameters:
- ADDR_W, 6, word-index width; depth = 2**ADDR_W words; valid byte addresses 0 .. 4*(2**ADDR_W)-1.
- WAIT_CYCLES, 2, wait states inserted between request acceptance and response; legal range 0..255.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high.
- req_valid  input  1  request present; sampled only when req_ready=1.
- req_ready  output  1  high only in IDLE.
- req_we  input  1  1 = write (STR), 0 = read (LDR or instruction fetch).
- req_addr  input  32  byte address.
- req_wdata  input  32  write data.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  32  read data; holds until the next response.
- rsp_err  output  1  qualified by rsp_valid; misaligned or out-of-range access.

Behaviour:
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0. Memory array is not reset. Simulation initial contents are all zero.
- FSM states are IDLE, WAIT, RESP.
- IDLE, req_valid=1 at the edge (accept):
  - Capture addr, we, and wdata into holding registers.
  - Load the 8-bit counter with WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, otherwise RESP.
- WAIT:
  - Counter decrements each edge.
  - When the counter equals 1 at an edge, next state is RESP.
  - Otherwise remain in WAIT.
- RESP:
  - rsp_valid=1 for exactly this cycle.
  - Next state is always IDLE. No back-to-back acceptance: req_ready is low in RESP.
- Memory access happens on the edge that enters RESP:
  - Write: array[word] <= held wdata; rsp_rdata <= held wdata.
  - Read: rsp_rdata <= array[word].
  - rsp_err is updated on the same edge.
- Latency: acceptance edge to first cycle with rsp_valid=1 is WAIT_CYCLES+1 cycles.
- Error (rsp_err=1) on misaligned access (addr[1:0]!=0) or out of range (addr[31:ADDR_W+2]!=0).
  - On error, the write is suppressed and rsp_rdata=0.
- Requests presented while req_ready=0 are ignored and not queued. Inputs are don't-care outside IDLE.
- Read-after-write: a read accepted in the IDLE cycle right after a write's RESP returns the new data.
- Reset mid-operation (WAIT or RESP): return to IDLE immediately.
  - A pending write that has not yet reached the RESP-entry edge is discarded.
  - Array contents are unchanged.
- rsp_rdata and rsp_err are stable between responses.

Optional Feature:
- Macro MEM_BYTE_LANE_EN.
- Defined:
  - Adds input req_byte (1 bit, captured at acceptance); 1 = byte access (LDRB/STRB).
  - Byte write updates only lane addr[1:0] (lane 0 = bits 7:0); the other lanes are untouched.
  - Byte read returns the zero-extended selected byte.
  - Misalignment check applies only to word accesses. The out-of-range check still applies.
- Undefined:
  - Port req_byte is absent.
  - All accesses are word accesses; behaviour is as above.

Test Plan:
1. Reset, WAIT_CYCLES=2: write 0xDEADBEEF to addr 0x10, then read addr 0x10.
   - Response: rsp_valid exactly 3 cycles after each acceptance; read rsp_rdata=0xDEADBEEF; rsp_err=0.
2. While in WAIT, pulse req_valid with a write of 0x12345678 to addr 0x10.
   - Response: ignored; req_ready=0; a later read of 0x10 still returns 0xDEADBEEF.
3. Write to addr 0x13, and separately to addr 0x100 (ADDR_W=6).
   - Response: rsp_err=1 and rsp_rdata=0 for each; subsequent reads of 0x10 and 0x0 are unchanged.
4. Accept a write of 0xAAAA5555 to addr 0x20, assert reset during WAIT, then release.
   - Response: state IDLE, rsp_valid=0; a read of 0x20 returns 0x00000000.
5. WAIT_CYCLES=0: read addr 0x10.
   - Response: rsp_valid on the cycle immediately after acceptance; rsp_rdata=0xDEADBEEF.
6. MEM_BYTE_LANE_EN defined: STRB 0x7F to addr 0x11 over a word of 0xDEADBEEF, then word read 0x10 and byte read 0x11.
   - Response: word read 0xDEAD7FEF; byte read 0x0000007F; rsp_err=0.
